fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h3000_0000: first instruction address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: instruction word driven when no valid instruction is presented.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ctrl_i_fetch_stall  input  1  downstream cannot accept this cycle.
REQ-006 exe_i_redirect  input  1  control-flow redirect request.
REQ-007 exe_i_redirect_pc  input  32  redirect target.
REQ-008 io_master_arvalid / io_master_araddr  output  1/32  read-address channel.
REQ-009 io_master_arready  input  1  address accepted.
REQ-010 io_master_rvalid / io_master_rdata / io_master_rresp  input  1/32/2  read-data channel.
REQ-011 io_master_rready  output  1  read-data accept.
REQ-012 fetch_o_instr  output  32  fetched instruction.
REQ-013 fetch_o_pc  output  32  address of fetch_o_instr.
REQ-014 fetch_o_pre_pc  output  32  predicted next PC, fetch_o_pc + 4.
REQ-015 fetch_o_commit  output  1  outputs hold a valid instruction.
REQ-016 fetch_o_fault  output  1  held instruction returned with rresp != 2'b00.

Function
REQ-017 FSM states: S_AR (arvalid=1), S_R (rready=1), S_HOLD (commit=1); no other states.
REQ-018 S_AR: araddr = pc; araddr stable while arvalid=1 and arready=0; arvalid && arready -> S_R.
REQ-019 S_R: rvalid && rready -> latch rdata into fetch_o_instr and (rresp != 0) into fetch_o_fault, then -> S_HOLD.
REQ-020 S_HOLD: commit=1; instr, pc, pre_pc and fault stay constant while ctrl_i_fetch_stall=1.
REQ-021 Handoff: commit=1 && stall=0 at posedge -> pc <= pc + 4, next state S_AR, commit=0 in the next cycle.
REQ-022 Minimum latency from entering S_AR to commit=1 is 2 cycles (arready and rvalid each asserted on the first possible cycle).
REQ-023 pre_pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 Redirect in S_AR before the address handshake: araddr changes to exe_i_redirect_pc next cycle; arvalid stays 1.
REQ-025 Redirect in S_AR coincident with arready, or in S_R: set a discard flag, complete the R handshake, drop its data, never assert commit for it, then issue S_AR at the redirect target.
REQ-026 Redirect in S_HOLD: drop the held instruction (commit=0 next cycle); go to S_AR with pc = redirect target.
REQ-027 Redirect and stall in the same cycle: redirect wins.
REQ-028 A redirect arriving while the discard flag is set overwrites the pending target; the last redirect wins.
REQ-029 When commit=0, fetch_o_instr = NOP_INSTR.
REQ-030 At most one outstanding read; arvalid and rready are never 1 in the same cycle.

Reset
REQ-031 rst=0 asynchronously forces state S_AR, pc = RESET_PC, discard flag = 0, commit = 0, fault = 0, instr = NOP_INSTR, pre_pc = RESET_PC + 4, and rready = 0.
REQ-032 While rst=0, io_master_arvalid = 0; arvalid asserts in the first cycle after rst rises.
REQ-033 Reset mid-transaction abandons the transaction; a late rvalid after reset is ignored, because rready = 0 in S_AR.

Structure
REQ-034 Shared define package: NOP_INSTR value, FSM state encodings, RESET_PC default.
REQ-035 The block is a single module with no sub-module; the downstream pipeline register consumes fetch_o_instr, fetch_o_pc, fetch_o_pre_pc and fetch_o_commit directly.

Verification
REQ-036 Reset release, arready=1 and rvalid=1 immediately, rdata=32'h0000_0297 -> araddr 32'h3000_0000; commit=1 on cycle 3; pc=32'h3000_0000; pre_pc=32'h3000_0004.
REQ-037 Stall held high 5 cycles in S_HOLD -> outputs are constant, arvalid=0, and fetch at 32'h3000_0004 begins the cycle after stall drops.
REQ-038 Redirect to 32'h8000_0100 while in S_R, rvalid delayed 3 cycles -> stale data is never committed; next araddr = 32'h8000_0100.
REQ-039 Redirect and stall asserted together in S_HOLD -> commit=0 next cycle; araddr = redirect target.
REQ-040 rresp=2'b10 -> commit=1 with fault=1; fault clears on the next fetch.
REQ-041 Reset asserted in S_R with pc=32'h8000_0040 -> arvalid=0 and rready=0 immediately; after release, araddr = 32'h3000_0000.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch block.
//   NOP_INSTR_DEF - instruction word shown when no valid instruction is held
//   RESET_PC_DEF  - default first fetch address after reset
//   state_e       - fetch FSM state encodings
//   pc_plus4()    - sequential next-PC helper (32-bit modulo)
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h3000_0000;

  typedef enum logic [1:0] {
    S_AR   = 2'd0,  // read-address phase, arvalid high
    S_R    = 2'd1,  // read-data phase, rready high
    S_HOLD = 2'd2   // instruction presented downstream, commit high
  } state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: AXI-lite style read channel between the fetch unit and memory.
//   master (fetch side): drives arvalid/araddr/rready, receives arready/rvalid/rdata/rresp
//   slave  (memory side): the mirror image
interface fetch_if;

  logic        arvalid;
  logic [31:0] araddr;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rready;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/fetch.sv
// fetch: single-outstanding instruction fetch unit.
//   clk, rst            - clock, asynchronous active-low reset
//   ctrl_i_fetch_stall  - downstream cannot take the held instruction
//   exe_i_redirect(_pc) - control-flow redirect and its target
//   io_master           - read-address / read-data channel to memory
//   fetch_o_instr/pc/pre_pc/commit/fault - instruction handed downstream
// The FSM walks S_AR -> S_R -> S_HOLD; only one read is ever in flight, so
// arvalid and rready are never asserted together.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ctrl_i_fetch_stall,
  input  logic         exe_i_redirect,
  input  logic [31:0]  exe_i_redirect_pc,
  fetch_if.master      io_master,
  output logic [31:0]  fetch_o_instr,
  output logic [31:0]  fetch_o_pc,
  output logic [31:0]  fetch_o_pre_pc,
  output logic         fetch_o_commit,
  output logic         fetch_o_fault
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic        discard_q, discard_d;
  logic        ar_hs;
  logic        r_hs;

  // arvalid is gated by rst so it is low for the whole reset period and rises
  // in the first cycle after release.
  assign io_master.arvalid = (state_q == S_AR) && rst;
  assign io_master.araddr  = pc_q;
  assign io_master.rready  = (state_q == S_R);

  assign ar_hs = io_master.arvalid && io_master.arready;
  assign r_hs  = io_master.rvalid && io_master.rready;

  assign fetch_o_commit = (state_q == S_HOLD);
  assign fetch_o_instr  = fetch_o_commit ? instr_q : NOP_INSTR;
  assign fetch_o_pc     = pc_q;
  assign fetch_o_pre_pc = pc_plus4(pc_q);
  assign fetch_o_fault  = fault_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    fault_d   = fault_q;
    discard_d = discard_q;

    case (state_q)
      S_AR: begin
        if (ar_hs) begin
          state_d = S_R;
          // A redirect coincident with the address handshake cannot cancel
          // the read; the returning data is dropped instead.
          if (exe_i_redirect) begin
            discard_d = 1'b1;
            pc_d      = exe_i_redirect_pc;
          end
        end else if (exe_i_redirect) begin
          pc_d = exe_i_redirect_pc;
        end
      end

      S_R: begin
        // pc already holds the pending redirect target while discarding, so a
        // later redirect simply overwrites it.
        if (exe_i_redirect) begin
          pc_d = exe_i_redirect_pc;
        end
        if (r_hs) begin
          if (discard_q || exe_i_redirect) begin
            discard_d = 1'b0;
            state_d   = S_AR;
          end else begin
            instr_d = io_master.rdata;
            fault_d = |io_master.rresp;
            state_d = S_HOLD;
          end
        end else if (exe_i_redirect) begin
          discard_d = 1'b1;
        end
      end

      S_HOLD: begin
        // Redirect takes priority over stall.
        if (exe_i_redirect) begin
          pc_d    = exe_i_redirect_pc;
          instr_d = NOP_INSTR;
          fault_d = 1'b0;
          state_d = S_AR;
        end else if (!ctrl_i_fetch_stall) begin
          pc_d    = pc_plus4(pc_q);
          instr_d = NOP_INSTR;
          fault_d = 1'b0;
          state_d = S_AR;
        end
      end

      default: begin
        state_d = S_AR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_AR;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      fault_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      fault_q   <= fault_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed testbench for the fetch unit. Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pre_pc;
  logic        commit;
  logic        fault;

  int total;
  int passed;

  fetch_if bus ();

  fetch #(
    .RESET_PC  (32'h3000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ctrl_i_fetch_stall (stall),
    .exe_i_redirect     (redirect),
    .exe_i_redirect_pc  (redirect_pc),
    .io_master          (bus),
    .fetch_o_instr      (instr),
    .fetch_o_pc         (pc),
    .fetch_o_pre_pc     (pre_pc),
    .fetch_o_commit     (commit),
    .fetch_o_fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = 32'h0;
    bus.rresp   = 2'b00;

    // Reset state
    tick();
    tick();
    check("rst_arvalid", bus.arvalid, 1'b0);
    check("rst_rready",  bus.rready,  1'b0);
    check("rst_commit",  commit,      1'b0);
    check("rst_fault",   fault,       1'b0);
    check("rst_instr",   instr,       32'h0000_0013);
    check("rst_pc",      pc,          32'h3000_0000);
    check("rst_pre_pc",  pre_pc,      32'h3000_0004);

    // First fetch, zero-wait memory; stall held so the instruction stays
    rst         = 1'b1;
    stall       = 1'b1;
    bus.arready = 1'b1;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h0000_0297;
    #1;
    check("t1_arvalid", bus.arvalid, 1'b1);
    check("t1_araddr",  bus.araddr,  32'h3000_0000);
    check("t1_rready0", bus.rready,  1'b0);
    tick();
    check("t1_rready1", bus.rready,  1'b1);
    check("t1_arv_r",   bus.arvalid, 1'b0);
    check("t1_commit0", commit,      1'b0);
    tick();
    check("t1_commit",  commit,      1'b1);
    check("t1_instr",   instr,       32'h0000_0297);
    check("t1_pc",      pc,          32'h3000_0000);
    check("t1_pre_pc",  pre_pc,      32'h3000_0004);
    check("t1_fault",   fault,       1'b0);

    // Stall held for five cycles in S_HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_commit",  commit,      1'b1);
      check("t2_instr",   instr,       32'h0000_0297);
      check("t2_pc",      pc,          32'h3000_0000);
      check("t2_pre_pc",  pre_pc,      32'h3000_0004);
      check("t2_arvalid", bus.arvalid, 1'b0);
    end
    stall       = 1'b0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    tick();
    check("t2_commit_off", commit,      1'b0);
    check("t2_instr_nop",  instr,       32'h0000_0013);
    check("t2_arvalid",    bus.arvalid, 1'b1);
    check("t2_araddr",     bus.araddr,  32'h3000_0004);
    tick();
    check("t2_araddr_hold", bus.araddr,  32'h3000_0004);
    check("t2_arv_hold",    bus.arvalid, 1'b1);

    // Redirect while in S_R, data returns late and must be dropped
    bus.arready = 1'b1;
    tick();
    check("t3_rready", bus.rready, 1'b1);
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0100;
    tick();
    redirect = 1'b0;
    check("t3_rready_wait", bus.rready, 1'b1);
    check("t3_commit_a",    commit,     1'b0);
    tick();
    check("t3_commit_b", commit, 1'b0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hDEAD_BEEF;
    tick();
    check("t3_commit_c", commit,      1'b0);
    check("t3_instr",    instr,       32'h0000_0013);
    check("t3_arvalid",  bus.arvalid, 1'b1);
    check("t3_araddr",   bus.araddr,  32'h8000_0100);
    check("t3_rready0",  bus.rready,  1'b0);
    bus.rdata = 32'h0000_0093;
    tick();
    tick();
    check("t3_commit",  commit, 1'b1);
    check("t3_instr2",  instr,  32'h0000_0093);
    check("t3_pc",      pc,     32'h8000_0100);
    check("t3_pre_pc",  pre_pc, 32'h8000_0104);

    // Redirect and stall together in S_HOLD
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0040;
    bus.arready = 1'b0;
    tick();
    redirect = 1'b0;
    check("t4_commit",  commit,      1'b0);
    check("t4_arvalid", bus.arvalid, 1'b1);
    check("t4_araddr",  bus.araddr,  32'h8000_0040);

    // Error response sets fault, next fetch clears it
    bus.arready = 1'b1;
    bus.rvalid  = 1'b1;
    bus.rresp   = 2'b10;
    bus.rdata   = 32'h0000_0073;
    tick();
    tick();
    check("t5_commit", commit, 1'b1);
    check("t5_fault",  fault,  1'b1);
    check("t5_instr",  instr,  32'h0000_0073);
    stall     = 1'b0;
    bus.rresp = 2'b00;
    bus.rdata = 32'h0000_0017;
    tick();
    check("t5_fault_clr", fault,      1'b0);
    check("t5_commit0",   commit,     1'b0);
    check("t5_araddr",    bus.araddr, 32'h8000_0044);
    tick();
    tick();
    check("t5_commit2", commit, 1'b1);
    check("t5_fault2",  fault,  1'b0);
    check("t5_pc2",     pc,     32'h8000_0044);

    // Reset asserted in S_R at pc 8000_0040; late rvalid after release
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0040;
    bus.rvalid  = 1'b0;
    tick();
    redirect = 1'b0;
    tick();
    check("t6_rready_pre", bus.rready, 1'b1);
    check("t6_pc_pre",     pc,         32'h8000_0040);
    bus.rvalid = 1'b1;
    rst        = 1'b0;
    #1;
    check("t6_arvalid", bus.arvalid, 1'b0);
    check("t6_rready",  bus.rready,  1'b0);
    check("t6_pc",      pc,          32'h3000_0000);
    check("t6_commit",  commit,      1'b0);
    tick();
    bus.arready = 1'b0;
    rst         = 1'b1;
    #1;
    check("t6_arvalid_rel", bus.arvalid, 1'b1);
    check("t6_araddr_rel",  bus.araddr,  32'h3000_0000);
    check("t6_rready_rel",  bus.rready,  1'b0);
    tick();
    check("t6_late_rready", bus.rready,  1'b0);
    check("t6_late_commit", commit,      1'b0);
    check("t6_late_arv",    bus.arvalid, 1'b1);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("t7_araddr", bus.araddr,  32'hFFFF_FFFC);
    check("t7_arvld",  bus.arvalid, 1'b1);
    bus.arready = 1'b1;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h0000_0013;
    tick();
    tick();
    check("t7_commit", commit, 1'b1);
    check("t7_pc",     pc,     32'hFFFF_FFFC);
    check("t7_pre_pc", pre_pc, 32'h0000_0000);
    tick();
    check("t7_wrap_araddr", bus.araddr, 32'h0000_0000);

    // Redirect coincident with the address handshake
    redirect    = 1'b1;
    redirect_pc = 32'h8000_0200;
    tick();
    redirect = 1'b0;
    check("t8_rready", bus.rready, 1'b1);
    check("t8_commit", commit,     1'b0);
    tick();
    check("t8_commit2", commit,      1'b0);
    check("t8_arvalid", bus.arvalid, 1'b1);
    check("t8_araddr",  bus.araddr,  32'h8000_0200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
